div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
- EX-stage issue and hold controller sitting directly upstream of the `divider` block.
- Accepts one div.w, div.wu, mod.w or mod.wu request per transaction from the EX pipeline over a valid/ready handshake.
- Registers operands and op, drives the divider's level-held op interface until completion, and captures the 32-bit result.
- Presents the result to the MEM-side consumer over valid/ready; supports pipeline flush, including cancellation of a division already in flight.

Parameters:
- TAG_W, 5: width of the destination-register tag carried with each request.
- QUIET_CYCLES, 40: cycles after reset during which no request is accepted, so a stale in-flight IP result drains.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  EX request valid.
- in_ready  out  1  controller can accept a request.
- in_op  in  4  one-hot op: 0001 div.w, 0010 div.wu, 0100 mod.w, 1000 mod.wu.
- in_src1  in  32  dividend.
- in_src2  in  32  divisor.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  pipeline flush; cancels the held or in-flight request.
- div_src1  out  32  to divider, registered dividend.
- div_src2  out  32  to divider, registered divisor.
- div_op  out  4  to divider, registered one-hot op; 0000 when idle.
- div_res  in  32  from divider.
- div_done  in  1  from divider, single-cycle completion strobe.
- res_valid  out  1  result valid to consumer.
- res_ready  in  1  consumer accepts.
- res_data  out  32  captured result.
- res_tag  out  TAG_W  tag of the result.
- busy  out  1  high in any state except IDLE; used by the hazard unit.

Behaviour:
- Reset values:
  - state = QUIET, quiet counter = QUIET_CYCLES-1.
  - div_op = 0, div_src1/div_src2 = 0.
  - res_valid = 0, res_data = 0, res_tag = 0.
  - in_ready = 0, busy = 1.
- States: QUIET, IDLE, BUSY, DRAIN, HOLD.
- QUIET:
  - Counter decrements each cycle; at 0 go to IDLE.
  - div_done is ignored; the divider asserts done during reset and may emit stale completions.
- IDLE:
  - in_ready = !flush.
  - When in_valid & in_ready: latch src1, src2, op and tag; next cycle div_op = latched op and state = BUSY.
  - in_op must be exactly one-hot; a non-one-hot op is not accepted (in_ready stays high, nothing latched).
  - div_done is ignored.
- BUSY:
  - div_op and operands held stable.
  - On div_done & !flush: capture div_res into res_data; next cycle div_op = 0, res_valid = 1, state = HOLD.
  - On flush & !div_done: go to DRAIN; div_op stays asserted because the divider cannot abort.
  - On flush & div_done in the same cycle: discard the result, div_op = 0, go to IDLE.
- DRAIN:
  - div_op held until div_done, which is discarded; next cycle div_op = 0 and state = IDLE.
  - flush has no further effect.
- HOLD:
  - res_valid = 1; res_data and res_tag are stable while res_ready = 0.
  - On res_ready: res_valid = 0 next cycle, state = IDLE.
  - On flush: res_valid = 0 next cycle, state = IDLE; flush takes priority over res_ready.
- div_op is deasserted the cycle after div_done. This guarantees the divider sees at least one cycle of op = 0 in its WAIT state and never relaunches the same request.
- Latency: acceptance at cycle t gives div_op at t+1. With divider completion at cycle d, res_valid is high from d+1. Minimum occupancy is one idle cycle between requests.
- Divide by zero is passed to the divider unchanged; the result is architecturally undefined and forwarded as is.
- reset mid-operation: all state is dropped and QUIET is re-entered. No result is emitted for the lost request.
- busy = (state != IDLE).

Decomposition:
- Shared package holds:
  - op one-hot constants DIV_W, DIV_WU, MOD_W, MOD_WU;
  - state encoding (one-hot, 5 bits);
  - the QUIET_CYCLES default.
- The 6-bit quiet counter is inline.
- No sub-module is needed; the divider is instantiated beside this block, not inside it.

Test Plan:
- div.w, src1 = 0xFFFFFFF9 (-7), src2 = 2 -> one result, res_data = 0xFFFFFFFD (-3); div_op returns to 0000 the cycle after div_done.
- mod.w -7 % 2 -> 0xFFFFFFFF; then mod.wu 100 % 7 -> 0x00000002; then div.wu 0xFFFFFFFF / 2 -> 0x7FFFFFFF, issued back to back. Expect exactly three results, in order, with correct tags 3, 4, 5.
- res_ready held low 5 cycles in HOLD -> res_valid stays 1, res_data/res_tag stable, in_ready = 0; on release, IDLE the next cycle.
- flush 3 cycles after accepting div.w 10/3 -> no res_valid ever asserted; div_op stays 0001 until div_done, then 0000. A following div.wu 9/3 returns 0x00000003.
- flush in the same cycle as div_done, and separately in HOLD -> result dropped, IDLE next cycle.
- reset asserted mid-BUSY -> outputs at reset values. in_ready stays 0 for 40 cycles, and spurious div_done pulses during QUIET produce no res_valid. A request after QUIET completes correctly.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: op codes, state encoding, defaults.
package div_issue_ctrl_pkg;

    localparam logic [3:0] DIV_W  = 4'b0001;
    localparam logic [3:0] DIV_WU = 4'b0010;
    localparam logic [3:0] MOD_W  = 4'b0100;
    localparam logic [3:0] MOD_WU = 4'b1000;

    localparam int QUIET_CYCLES_DEF = 40;

    typedef enum logic [4:0] {
        ST_QUIET = 5'b00001,
        ST_IDLE  = 5'b00010,
        ST_BUSY  = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_HOLD  = 5'b10000
    } state_e;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op == DIV_W) || (op == DIV_WU) || (op == MOD_W) || (op == MOD_WU);
    endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Issue/hold controller in front of the divider: latches one request, holds the op until
// completion, then presents the result downstream. Request-to-op latency 1, done-to-valid 1.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int TAG_W        = 5,
    parameter int QUIET_CYCLES = QUIET_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_src1,
    input  logic [31:0]      in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [31:0]      div_src1,
    output logic [31:0]      div_src2,
    output logic [3:0]       div_op,
    input  logic [31:0]      div_res,
    input  logic             div_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    localparam logic [5:0] QUIET_INIT = 6'(QUIET_CYCLES - 1);

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      src1_q, src1_d;
    logic [31:0]      src2_q, src2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rvld_q, rvld_d;
    logic [31:0]      rdat_q, rdat_d;
    logic [TAG_W-1:0] rtag_q, rtag_d;
    logic             accept;

    assign in_ready = (state_q == ST_IDLE) && !flush;
    assign accept   = in_ready && in_valid && is_valid_op(in_op);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        tag_d   = tag_q;
        rvld_d  = rvld_q;
        rdat_d  = rdat_q;
        rtag_d  = rtag_q;
        case (state_q)
            // Stale completions from the divider are drained here, so div_done is ignored.
            ST_QUIET: begin
                if (cnt_q == 6'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 6'd1;
            end
            ST_IDLE: begin
                if (accept) begin
                    src1_d  = in_src1;
                    src2_d  = in_src2;
                    op_d    = in_op;
                    tag_d   = in_tag;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (div_done) begin
                    op_d = 4'b0000;
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        rdat_d  = div_res;
                        rtag_d  = tag_q;
                        rvld_d  = 1'b1;
                        state_d = ST_HOLD;
                    end
                end else if (flush) begin
                    // The divider cannot abort; keep op asserted and swallow its completion.
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (div_done) begin
                    op_d    = 4'b0000;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (flush || res_ready) begin
                    rvld_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_QUIET;
                cnt_d   = QUIET_INIT;
                op_d    = 4'b0000;
                rvld_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_QUIET;
            cnt_q   <= QUIET_INIT;
            op_q    <= 4'b0000;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            tag_q   <= '0;
            rvld_q  <= 1'b0;
            rdat_q  <= 32'd0;
            rtag_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            tag_q   <= tag_d;
            rvld_q  <= rvld_d;
            rdat_q  <= rdat_d;
            rtag_q  <= rtag_d;
        end
    end

    assign div_op    = op_q;
    assign div_src1  = src1_q;
    assign div_src2  = src2_q;
    assign res_valid = rvld_q;
    assign res_data  = rdat_q;
    assign res_tag   = rtag_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
